// File: rtl/wb_ram_tester_pkg.sv
// Shared types and pattern helper for the Wishbone RAM self-test engine.
package wb_ram_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned ERR_W = 16;

  // Test pattern: word address XOR seed, computed at the widest supported data width.
  function automatic logic [31:0] expected(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Raw active-low button synchroniser with press (falling input) edge detector.
module btn_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic [STAGES-1:0] sync_q;
  logic              held_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      held_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], btn_n};
      held_q <= ~sync_q[STAGES-1];
    end
  end

  assign press = ~sync_q[STAGES-1] & ~held_q;

endmodule

// File: rtl/sseg.sv
// Hex nibble to active-low seven-segment decoder; seg[0] is segment a, seg[6] is g.
module sseg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = '1;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = '1;
    endcase
  end

endmodule

// File: rtl/wb_ram_tester.sv
// Wishbone classic RAM self-test master: write seeded pattern, read back, count mismatches.
// Optional ack timeout enabled by defining WB_RAM_TESTER_TIMEOUT_EN.
module wb_ram_tester
  import wb_ram_tester_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WORDS       = 1024,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start_n,
  input  logic [DATA_W-1:0]     io_seed,
  input  logic                  io_disp_sel,
  output logic [ADDR_W-1:0]     wb_adr,
  output logic [DATA_W-1:0]     wb_dat_o,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W/8-1:0]   wb_sel,
  output logic                  wb_we,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  input  logic                  wb_ack,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  stall,
  output logic                  pass,
  output logic                  fail
);

  localparam int unsigned      HEX_W = 4 * DIGITS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  if (DATA_W % 4 != 0 || DATA_W < 8 || DATA_W > 32 || DIGITS < 1 || DIGITS > 8 ||
      SYNC_STAGES < 2 || WORDS < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("wb_ram_tester: illegal parameter combination");
  end

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] s);
    logic [63:0] a_ext;
    logic [31:0] p;
    a_ext = 64'(a);
    p     = expected(a_ext[31:0], 32'(s));
    return p[DATA_W-1:0];
  endfunction

  state_t            state;
  logic [DATA_W-1:0] seed;
  logic [ERR_W-1:0]  err;
  logic [ERR_W-1:0]  err_next;
  logic [ADDR_W-1:0] first_fail;
  logic              start_evt;
  logic              xfer_done;
  logic              mismatch;
  logic              at_last;
  logic [HEX_W-1:0]  disp;

  btn_sync #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clock (clock),
    .reset (reset),
    .btn_n (io_start_n),
    .press (start_evt)
  );

  assign xfer_done = wb_stb && wb_ack;
  assign mismatch  = (wb_dat_i != pattern(wb_adr, seed));
  assign at_last   = (wb_adr == LAST);

  always_comb begin
    err_next = err;
    if (state == READ && xfer_done && mismatch && err != '1)
      err_next = err + 1'b1;
  end

`ifdef WB_RAM_TESTER_TIMEOUT_EN
  localparam int unsigned WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;

  // Every ack ends a strobe, so clearing on ack restarts the count for the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (!wb_stb || wb_ack)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = wb_stb && !wb_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      seed       <= '0;
      err        <= '0;
      first_fail <= '0;
      wb_adr     <= '0;
      wb_dat_o   <= '0;
      wb_we      <= 1'b0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
`ifdef WB_RAM_TESTER_TIMEOUT_EN
      if (timeout_hit) begin
        state      <= DONE;
        wb_cyc     <= 1'b0;
        wb_stb     <= 1'b0;
        wb_we      <= 1'b0;
        err        <= '1;
        first_fail <= wb_adr;
        pass       <= 1'b0;
        fail       <= 1'b1;
      end else
`endif
      case (state)
        IDLE, DONE: begin
          if (start_evt) begin
            state      <= WRITE;
            seed       <= io_seed;
            wb_adr     <= '0;
            wb_dat_o   <= pattern('0, io_seed);
            err        <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            wb_cyc     <= 1'b1;
            wb_stb     <= 1'b1;
            wb_we      <= 1'b1;
          end
        end
        WRITE: begin
          if (xfer_done) begin
            if (at_last) begin
              state    <= READ;
              wb_adr   <= '0;
              wb_dat_o <= '0;
              wb_we    <= 1'b0;
            end else begin
              wb_adr   <= wb_adr + 1'b1;
              wb_dat_o <= pattern(wb_adr + 1'b1, seed);
            end
          end
        end
        READ: begin
          if (xfer_done) begin
            err <= err_next;
            if (mismatch && err == '0)
              first_fail <= wb_adr;
            if (at_last) begin
              state  <= DONE;
              wb_cyc <= 1'b0;
              wb_stb <= 1'b0;
              pass   <= (err_next == '0);
              fail   <= (err_next != '0);
            end else begin
              wb_adr <= wb_adr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_sel = '1;
  assign busy   = (state == WRITE) || (state == READ);
  assign stall  = wb_stb && !wb_ack;

  always_comb begin
    disp = HEX_W'(io_disp_sel ? 64'(first_fail) : 64'(err));
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    sseg u_sseg (
      .nibble (disp[4*i +: 4]),
      .seg    (hex[7*i +: 7])
    );
  end

endmodule

// File: doc/wb_ram_tester.md
Name: wb_ram_tester

Overview:
- Parametrised board-level SDRAM/RAM self-test engine; successor to the single-word switch-driven test harness.
- Acts as a Wishbone classic master: writes a seeded pattern over a configurable word range, reads it back, compares, counts mismatches and records the first failing address.
- Synchronises raw board buttons internally and drives DIGITS seven-segment displays.
- Sits between board pins and the SDRAM Wishbone slave.

Parameters:
- ADDR_W, 24, Wishbone word-address width.
- DATA_W, 16, Wishbone data width; must be a multiple of 4 and at most 32.
- WORDS, 1024, number of words tested, from address 0 to WORDS-1; 1 <= WORDS <= 2^ADDR_W.
- DIGITS, 4, seven-segment digits driven; at most 8.
- SYNC_STAGES, 2, flip-flop stages on each raw button input; minimum 2.
- TIMEOUT, 255, maximum ack wait in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- io_start_n  in  1  raw start button, active-low, asynchronous to clock.
- io_seed  in  DATA_W  pattern seed; sampled at start.
- io_disp_sel  in  1  display select: 0 = error count, 1 = first-fail address.
- wb_adr  out  ADDR_W  word address.
- wb_dat_o  out  DATA_W  write data.
- wb_dat_i  in  DATA_W  read data.
- wb_sel  out  DATA_W/8  byte lanes; always all ones.
- wb_we  out  1  write enable.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_ack  in  1  slave acknowledge.
- hex  out  7*DIGITS  active-low segments; digit 0 in bits [6:0].
- busy  out  1  test in progress.
- stall  out  1  wb_stb && !wb_ack.
- pass  out  1  last test finished with zero errors.
- fail  out  1  last test finished with errors or a timeout.

Behaviour:
- Reset:
  - reset low forces state IDLE immediately.
  - All registers and outputs go to 0: wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, error count, first-fail address, busy, pass, fail.
  - hex shows all digits as "0".
  - Reset asserted mid-transfer drops wb_cyc/wb_stb at once; the slave must tolerate this.
- Start input:
  - io_start_n passes through SYNC_STAGES flip-flops (reset value 1) and is inverted.
  - A start event is a rising edge of the synchronised, inverted signal (button press).
  - Start events are ignored outside IDLE and DONE.
- State machine (IDLE, WRITE, READ, DONE):
  - IDLE or DONE, on start:
    - seed <= io_seed; addr <= 0; err <= 0; first_fail <= 0; pass <= 0; fail <= 0; go to WRITE.
  - WRITE:
    - Drive cyc=stb=we=1, wb_adr=addr, wb_dat_o = addr[DATA_W-1:0] ^ seed (address zero-extended if ADDR_W < DATA_W).
    - On ack: if addr == WORDS-1, set addr <= 0 and go to READ; otherwise addr++.
    - stb stays high back-to-back, so a transfer completes in one cycle when ack is held.
  - READ:
    - Drive cyc=stb=1, we=0.
    - On ack, compare wb_dat_i against the expected pattern.
    - On mismatch: err saturates at 2^16-1; first_fail latches addr only on the first mismatch.
    - At addr == WORDS-1 after ack: go to DONE.
  - DONE:
    - cyc=stb=0; pass = (err == 0); fail = !pass.
- Output timing:
  - busy = state is WRITE or READ.
  - Outputs are registered; wb_stb rises the cycle after the start edge is detected.
- Display:
  - io_disp_sel selects err (16 bits) or first_fail (low 4*DIGITS bits), zero-extended or truncated to 4*DIGITS bits.
  - One nibble per digit through the seven-segment decoder.
  - Display updates live during a run.
- Boundaries:
  - WORDS = 1: a single write then a single read.
  - The address counter never exceeds WORDS-1.
  - An ack arriving while stb=0 is ignored.

Optional Feature:
- Macro: WB_RAM_TESTER_TIMEOUT_EN.
- Defined:
  - An 8+ bit wait counter clears on each new strobe and counts cycles with stb && !ack.
  - Reaching TIMEOUT: drop cyc/stb, set err to all ones, first_fail <= addr, go to DONE (fail=1).
- Undefined:
  - No counter; the tester waits on ack indefinitely.

Decomposition:
- Package wb_ram_tester_pkg holds:
  - state enum typedef (IDLE, WRITE, READ, DONE);
  - ERR_W = 16 constant;
  - function expected(addr, seed) returning the pattern.
- Sub-module btn_sync: SYNC_STAGES-deep synchroniser plus edge detector, instantiated for io_start_n.
- Digits reuse the existing sseg decoder, one instance per digit in a generate loop.

Test Plan:
- Zero-wait slave model (ack same cycle as stb), WORDS=16, seed=16'hA5A5, press start:
  - exactly 16 writes with data addr^A5A5, then 16 reads;
  - DONE after 32 acks; pass=1, err=0, hex=0000.
- Slave corrupts read data at addr 5 and addr 9 (bit 0 flipped):
  - err=2, first_fail=5, fail=1;
  - hex=0002 with io_disp_sel=0 and 0005 with io_disp_sel=1.
- Slave inserts 3 wait states per access:
  - stall high 3 cycles per transfer;
  - no address advance before ack; pass=1.
- Start pressed during WRITE, then reset pulsed low mid-READ:
  - the start press is ignored;
  - on reset, cyc/stb drop the same cycle and all outputs return to 0.
- With WB_RAM_TESTER_TIMEOUT_EN, TIMEOUT=10, slave never acks:
  - DONE after 10 wait cycles; err=16'hFFFF, fail=1, first_fail=0.
- Start button bounce (0/1 toggles within a single cycle, then held low):
  - exactly one start event;
  - WORDS=1 run gives one write and one read, pass=1.
